// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable low/high occupancy thresholds (bajo/alto).
// Latency: 1 cycle from pop to data_out/valid_out; flags combinational from registered count.
// Backpressure: push refused when full (unless popping in the same cycle), pop refused when empty.
// Optional feature macro: FIFO_ERROR_EN adds sticky err_overflow / err_underflow outputs.
module fifo_umbrales #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [CNT_W-1:0]  umbral_bajo,
    input  logic [CNT_W-1:0]  umbral_alto,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CNT_W-1:0]  fifo_count
`ifdef FIFO_ERROR_EN
    ,
    output logic              err_overflow,
    output logic              err_underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ALTO_RST_C  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] BAJO_RST_C  = CNT_W'(1);

    // Storage is never cleared: the pointers/count define what is valid.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q,  valid_d;
    logic [CNT_W-1:0]  bajo_q,   bajo_d;
    logic [CNT_W-1:0]  alto_q,   alto_d;

    logic wr_en;
    logic rd_en;

`ifdef FIFO_ERROR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
`endif

    // Status flags derive only from the registered count and thresholds.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == DEPTH_C);
        almost_empty = (count_q <= bajo_q);
        almost_full  = (count_q >= alto_q);
    end

    // Accept logic and next-state computation; a simultaneous pop frees the slot
    // for a push when full, but an empty FIFO never forwards a same-cycle push.
    always_comb begin
        wr_en      = push && (!full || pop);
        rd_en      = pop && !empty;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        bajo_d     = bajo_q;
        alto_d     = alto_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        if (rd_en) begin
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            data_out_d = mem[rd_ptr_q];
            valid_d    = 1'b1;
        end

        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end

        // Thresholds are taken as given: no ordering or range check.
        if (init) begin
            bajo_d = umbral_bajo;
            alto_d = umbral_alto;
        end
    end

`ifdef FIFO_ERROR_EN
    // Sticky error flags record any refused push or pop until the next reset.
    always_comb begin
        ovf_d = ovf_q | (push && !wr_en);
        unf_d = unf_q | (pop && !rd_en);
    end
`endif

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            bajo_q     <= BAJO_RST_C;
            alto_q     <= ALTO_RST_C;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            bajo_q     <= bajo_d;
            alto_q     <= alto_d;
        end
    end

    // Memory write; suppressed during reset so a reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_ERROR_EN
    // Error flag registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
`endif

    assign data_out   = data_out_q;
    assign valid_out  = valid_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Testbench for fifo_umbrales: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_umbrales;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [2:0] umbral_bajo = '0;
    logic [2:0] umbral_alto = '0;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] fifo_count;
`ifdef FIFO_ERROR_EN
    logic       err_overflow;
    logic       err_underflow;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [5:0] m_q [$];
    int         m_bajo = 1;
    int         m_alto = 3;
    logic [5:0] m_dout = '0;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    fifo_umbrales #(.DATA_W(6), .ADDR_W(2), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_bajo  (umbral_bajo),
        .umbral_alto  (umbral_alto),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .fifo_count   (fifo_count)
`ifdef FIFO_ERROR_EN
        ,
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
`endif
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic cycle(input logic rst, input logic ini, input logic [2:0] b,
                         input logic [2:0] a, input logic ps, input logic [5:0] d,
                         input logic pp);
        bit can_wr;
        bit can_rd;
        reset = rst; init = ini; umbral_bajo = b; umbral_alto = a;
        push = ps; data_in = d; pop = pp;
        if (!rst) begin
            m_q.delete();
            m_bajo = 1; m_alto = 3; m_dout = '0; m_valid = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            can_wr = ps && (m_q.size() < 4 || pp);
            can_rd = pp && (m_q.size() > 0);
            if (ps && !can_wr) m_ovf = 1'b1;
            if (pp && !can_rd) m_unf = 1'b1;
            if (can_rd) begin
                m_dout = m_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (can_wr) m_q.push_back(d);
            if (ini) begin
                m_bajo = int'(b);
                m_alto = int'(a);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic do_push(input logic [5:0] d);
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, d, 1'b0);
    endtask

    task automatic do_pop();
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 6'd0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        idle();
        vectors++;
        if ({empty, almost_empty, full, almost_full, valid_out} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_flags: got e/ae/f/af/v=%b required 11000",
                     {empty, almost_empty, full, almost_full, valid_out});
        end
        vectors++;
        if (fifo_count !== 3'd0 || data_out !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_count: got count=%0d dout=%h required 0/00", fifo_count, data_out);
        end
`ifdef FIFO_ERROR_EN
        vectors++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got ovf=%b unf=%b required 0/0", err_overflow, err_underflow);
        end
`endif
    endtask

    task automatic test_thresholds();
        logic [5:0] words [4];
        logic [3:0] exp_ae;
        logic [3:0] exp_af;
        logic [3:0] exp_f;
        words[0] = 6'h0A; words[1] = 6'h0B; words[2] = 6'h0C; words[3] = 6'h0D;
        exp_ae = 4'b0001;  // bit i = expected flag after push i+1
        exp_af = 4'b1100;
        exp_f  = 4'b1000;
        cycle(1'b1, 1'b1, 3'd1, 3'd3, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_push(words[i]);
            vectors++;
            if (fifo_count !== 3'(i + 1) || almost_empty !== exp_ae[i] ||
                almost_full !== exp_af[i] || full !== exp_f[i]) begin
                miscompares++;
                $display("FAIL thresholds push%0d: got count=%0d ae=%b af=%b f=%b required %0d/%b/%b/%b",
                         i, fifo_count, almost_empty, almost_full, full,
                         i + 1, exp_ae[i], exp_af[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_overflow_drain();
        logic [5:0] words [4];
        words[0] = 6'h0A; words[1] = 6'h0B; words[2] = 6'h0C; words[3] = 6'h0D;
        do_push(6'h3F);
        vectors++;
        if (fifo_count !== 3'd4 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_ignored: got count=%0d full=%b required 4/1", fifo_count, full);
        end
`ifdef FIFO_ERROR_EN
        vectors++;
        if (err_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_flag: got %b required 1", err_overflow);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            do_pop();
            vectors++;
            if (data_out !== words[i] || valid_out !== 1'b1) begin
                miscompares++;
                $display("FAIL drain%0d: got dout=%h v=%b required %h/1",
                         i, data_out, valid_out, words[i]);
            end
        end
        idle();
        vectors++;
        if (valid_out !== 1'b0 || empty !== 1'b1 || data_out !== 6'h0D) begin
            miscompares++;
            $display("FAIL drain_end: got v=%b e=%b dout=%h required 0/1/0d",
                     valid_out, empty, data_out);
        end
    endtask

    task automatic test_full_pushpop();
        logic [5:0] exp [4];
        exp[0] = 6'h02; exp[1] = 6'h03; exp[2] = 6'h04; exp[3] = 6'h15;
        for (int i = 1; i <= 4; i++) do_push(6'(i));
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 6'h15, 1'b1);
        vectors++;
        if (fifo_count !== 3'd4 || data_out !== 6'h01 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pushpop: got count=%0d dout=%h v=%b required 4/01/1",
                     fifo_count, data_out, valid_out);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            vectors++;
            if (data_out !== exp[i]) begin
                miscompares++;
                $display("FAIL full_order%0d: got %h required %h", i, data_out, exp[i]);
            end
        end
    endtask

    task automatic test_empty_pushpop();
        cycle(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 6'h07, 1'b1);
        vectors++;
        if (valid_out !== 1'b0 || fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL empty_pushpop: got v=%b count=%0d required 0/1", valid_out, fifo_count);
        end
        do_pop();
        vectors++;
        if (data_out !== 6'h07 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_readback: got dout=%h v=%b required 07/1", data_out, valid_out);
        end
        do_pop();
        vectors++;
        if (valid_out !== 1'b0 || data_out !== 6'h07 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL underflow_ignored: got v=%b dout=%h count=%0d required 0/07/0",
                     valid_out, data_out, fifo_count);
        end
`ifdef FIFO_ERROR_EN
        vectors++;
        if (err_underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow_flag: got %b required 1", err_underflow);
        end
`endif
    endtask

    task automatic test_reset_midop();
        logic [5:0] w [6];
        cycle(1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 6'd0, 1'b0);
        do_push(6'h11);
        do_push(6'h12);
        do_reset();
        vectors++;
        if (fifo_count !== 3'd0 || empty !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset: got count=%0d e=%b v=%b required 0/1/0",
                     fifo_count, empty, valid_out);
        end
        // Thresholds back to 1/3: one word still almost_empty, three words almost_full.
        do_push(6'h21);
        vectors++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_thr1: got ae=%b af=%b required 1/0", almost_empty, almost_full);
        end
        do_push(6'h22);
        do_push(6'h23);
        vectors++;
        if (almost_empty !== 1'b0 || almost_full !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_thr3: got ae=%b af=%b required 0/1", almost_empty, almost_full);
        end
        do_pop(); do_pop(); do_pop();
        vectors++;
        if (data_out !== 6'h23) begin
            miscompares++;
            $display("FAIL reset_order: got %h required 23", data_out);
        end
        for (int i = 0; i < 6; i++) begin
            w[i] = 6'($urandom);
            do_push(w[i]);
            do_pop();
            vectors++;
            if (data_out !== w[i] || valid_out !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap%0d: got dout=%h v=%b required %h/1", i, data_out, valid_out, w[i]);
            end
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       ini;
        logic [2:0] b;
        logic [2:0] a;
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 59) != 0);
            ini = ($urandom_range(0, 9) == 0);
            b   = 3'($urandom);
            a   = 3'($urandom);
            cycle(r, ini, b, a, 1'($urandom), 6'($urandom), 1'($urandom));
            vectors++;
            if (fifo_count !== 3'(m_q.size()) || data_out !== m_dout || valid_out !== m_valid ||
                empty !== (m_q.size() == 0) || full !== (m_q.size() == 4) ||
                almost_empty !== (m_q.size() <= m_bajo) ||
                almost_full !== (m_q.size() >= m_alto)) begin
                miscompares++;
                $display("FAIL random%0d: got cnt=%0d dout=%h v=%b e/f/ae/af=%b%b%b%b required cnt=%0d dout=%h v=%b e/f/ae/af=%b%b%b%b",
                         n, fifo_count, data_out, valid_out, empty, full, almost_empty, almost_full,
                         m_q.size(), m_dout, m_valid, m_q.size() == 0, m_q.size() == 4,
                         m_q.size() <= m_bajo, m_q.size() >= m_alto);
            end
`ifdef FIFO_ERROR_EN
            vectors++;
            if (err_overflow !== m_ovf || err_underflow !== m_unf) begin
                miscompares++;
                $display("FAIL random_err%0d: got ovf=%b unf=%b required %b/%b",
                         n, err_overflow, err_underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_thresholds();
        test_overflow_drain();
        test_full_pushpop();
        test_empty_pushpop();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
